// File: rtl/jogador_automatico_memoria.sv
// Automatic memory-game player: records the one-hot LEDs shown during the
// sequence preview and replays them on the game's buttons.
module jogador_automatico_memoria #(
    parameter int PRESS_CYCLES = 5,
    parameter int GAP_CYCLES   = 5,
    parameter int IDLE_CYCLES  = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       iniciar,
    input  logic [3:0] leds,
    input  logic       pronto,
    output logic [3:0] botoes,
    output logic       jogar,
    output logic       ocupado,
    output logic [3:0] db_estado,
    output logic [4:0] db_contagem,
    output logic       db_erro
);

    localparam int HOLD_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int IDLE_W   = $clog2(IDLE_CYCLES + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [IDLE_W-1:0] IDLE_LIM   = IDLE_W'(IDLE_CYCLES);
    localparam logic [HOLD_W-1:0] PRESS_LAST = HOLD_W'(PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] GAP_LAST   = HOLD_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PEDE_JOGO = 4'd1,
        OBSERVA   = 4'd2,
        PRESSIONA = 4'd3,
        SOLTA     = 4'd4,
        FIM       = 4'd5
    } estado_t;

    estado_t           estado;
    logic [3:0]        buffer [16];
    logic [4:0]        cnt;
    logic [3:0]        idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        leds_q;

    logic       captura;
    logic       cheio;
    logic       grava;
    logic       fim_previa;
    logic       ultimo;
    logic [3:0] idx_prox;

    function automatic logic one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign captura  = (leds_q == 4'd0) && (leds != 4'd0);
    assign cheio    = cnt[4];
    assign grava    = habilita && !pronto && (estado == OBSERVA) &&
                      captura && one_hot(leds) && !cheio;
    // A lit LED in the threshold cycle is a new capture, not the end of the preview.
    assign fim_previa = (idle_cnt == IDLE_LIM) && (leds == 4'd0) && (cnt != 5'd0);
    assign ultimo     = (({1'b0, idx}) + 5'd1) == cnt;
    assign idx_prox   = idx + 4'd1;

    assign db_estado   = estado;
    assign db_contagem = cnt;

    always_ff @(posedge clock) begin
        if (grava) begin
            buffer[cnt[3:0]] <= leds;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            cnt      <= '0;
            idx      <= '0;
            idle_cnt <= '0;
            hold_cnt <= '0;
            leds_q   <= '0;
            botoes   <= '0;
            jogar    <= 1'b0;
            ocupado  <= 1'b0;
            db_erro  <= 1'b0;
        end else begin
            leds_q <= leds;
            jogar  <= 1'b0;
            if (!habilita) begin
                estado  <= INICIAL;
                botoes  <= '0;
                ocupado <= 1'b0;
            end else if (pronto && (estado == OBSERVA || estado == PRESSIONA || estado == SOLTA)) begin
                estado  <= FIM;
                botoes  <= '0;
                ocupado <= 1'b0;
            end else begin
                case (estado)
                    INICIAL, FIM: begin
                        botoes  <= '0;
                        ocupado <= 1'b0;
                        if (iniciar) begin
                            estado  <= PEDE_JOGO;
                            jogar   <= 1'b1;
                            ocupado <= 1'b1;
                        end
                    end
                    PEDE_JOGO: begin
                        cnt      <= '0;
                        idle_cnt <= '0;
                        db_erro  <= 1'b0;
                        estado   <= OBSERVA;
                    end
                    OBSERVA: begin
                        if (captura) begin
                            if (one_hot(leds) && !cheio) begin
                                cnt <= cnt + 5'd1;
                            end else begin
                                db_erro <= 1'b1;
                            end
                        end
                        if (leds != 4'd0) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt != IDLE_LIM) begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                        if (fim_previa) begin
                            idx      <= '0;
                            hold_cnt <= '0;
                            botoes   <= buffer[0];
                            estado   <= PRESSIONA;
                        end
                    end
                    PRESSIONA: begin
                        if (hold_cnt == PRESS_LAST) begin
                            hold_cnt <= '0;
                            botoes   <= '0;
                            estado   <= SOLTA;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    SOLTA: begin
                        if (hold_cnt == GAP_LAST) begin
                            hold_cnt <= '0;
                            if (ultimo) begin
                                cnt      <= '0;
                                idle_cnt <= '0;
                                estado   <= OBSERVA;
                            end else begin
                                idx    <= idx_prox;
                                botoes <= buffer[idx_prox];
                                estado <= PRESSIONA;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: begin
                        estado  <= INICIAL;
                        botoes  <= '0;
                        ocupado <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jogador_automatico_memoria.sv
// Self-checking bench for jogador_automatico_memoria: directed scenarios plus
// randomized games, checked every cycle against a queue-based player model.
module tb_jogador_automatico_memoria;

    localparam int PRESS = 5;
    localparam int GAP   = 5;
    localparam int IDLE  = 100;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       habilita = 1'b0;
    logic       iniciar  = 1'b0;
    logic       pronto   = 1'b0;
    logic [3:0] leds     = 4'd0;
    logic [3:0] botoes;
    logic       jogar;
    logic       ocupado;
    logic [3:0] db_estado;
    logic [4:0] db_contagem;
    logic       db_erro;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    jogador_automatico_memoria #(
        .PRESS_CYCLES(PRESS),
        .GAP_CYCLES  (GAP),
        .IDLE_CYCLES (IDLE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .iniciar    (iniciar),
        .leds       (leds),
        .pronto     (pronto),
        .botoes     (botoes),
        .jogar      (jogar),
        .ocupado    (ocupado),
        .db_estado  (db_estado),
        .db_contagem(db_contagem),
        .db_erro    (db_erro)
    );

    // Reference player: mode codes are the externally visible state codes;
    // m_seq holds the recorded sequence, m_timer counts cycles left in a phase.
    int         m_mode  = 0;
    int         m_dark  = 0;
    int         m_step  = 0;
    int         m_timer = 0;
    logic [3:0] m_prev  = 4'd0;
    logic [3:0] m_last;
    logic       m_erro  = 1'b0;
    logic [3:0] m_seq[$];

    task automatic model_step();
        m_last = m_prev;
        m_prev = leds;
        if (!habilita) begin
            m_mode = 0;
        end else if (pronto && m_mode >= 2 && m_mode <= 4) begin
            m_mode = 5;
        end else begin
            case (m_mode)
                0, 5: if (iniciar) m_mode = 1;
                1: begin
                    m_seq.delete();
                    m_dark = 0;
                    m_erro = 1'b0;
                    m_mode = 2;
                end
                2: begin
                    if (m_dark == IDLE && leds == 4'd0 && m_seq.size() > 0) begin
                        m_mode  = 3;
                        m_step  = 0;
                        m_timer = PRESS;
                    end
                    if (m_last == 4'd0 && leds != 4'd0) begin
                        if ($countones(leds) == 1 && m_seq.size() < 16) m_seq.push_back(leds);
                        else m_erro = 1'b1;
                    end
                    if (leds != 4'd0) m_dark = 0;
                    else if (m_dark < IDLE) m_dark = m_dark + 1;
                end
                3: begin
                    m_timer = m_timer - 1;
                    if (m_timer == 0) begin
                        m_mode  = 4;
                        m_timer = GAP;
                    end
                end
                4: begin
                    m_timer = m_timer - 1;
                    if (m_timer == 0) begin
                        if (m_step + 1 == m_seq.size()) begin
                            m_seq.delete();
                            m_dark = 0;
                            m_mode = 2;
                        end else begin
                            m_step  = m_step + 1;
                            m_mode  = 3;
                            m_timer = PRESS;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_mode  = 0;
                m_dark  = 0;
                m_step  = 0;
                m_timer = 0;
                m_prev  = 4'd0;
                m_erro  = 1'b0;
                m_seq.delete();
            end else begin
                model_step();
            end
        end
    end

    function automatic logic [15:0] model_outputs();
        logic [3:0] eb;
        eb = (m_mode == 3 && m_step < m_seq.size()) ? m_seq[m_step] : 4'd0;
        return {eb, 1'(m_mode == 1), 1'(m_mode >= 1 && m_mode <= 4),
                4'(m_mode), 5'(m_seq.size()), m_erro};
    endfunction

    initial begin
        logic [15:0] act;
        logic [15:0] exp;
        forever begin
            @(negedge clock);
            act = {botoes, jogar, ocupado, db_estado, db_contagem, db_erro};
            exp = model_outputs();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cycle_model t=%0t got bot=%b jog=%b ocu=%b est=%0d cnt=%0d err=%b want bot=%b jog=%b ocu=%b est=%0d cnt=%0d err=%b",
                         $time, act[15:12], act[11], act[10], act[9:6], act[5:1], act[0],
                         exp[15:12], exp[11], exp[10], exp[9:6], exp[5:1], exp[0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic show(input logic [3:0] v, input int on, input int off);
        leds = v;
        repeat (on) tick();
        leds = 4'd0;
        repeat (off) tick();
    endtask

    task automatic start();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("jogar_pulse_high", int'(jogar), 1);
        tick();
        chk("jogar_pulse_low", int'(jogar), 0);
    endtask

    task automatic wait_state(input logic [3:0] st, input int bound, input string nm);
        int n;
        n = 0;
        while (db_estado != st && n < bound) begin
            tick();
            n++;
        end
        chk(nm, int'(db_estado), int'(st));
    endtask

    task automatic random_game();
        int n, lim, pr_at;
        logic [3:0] v;
        bit echo;
        start();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) v = 4'($urandom_range(1, 15));
            else v = 4'b0001 << $urandom_range(0, 3);
            show(v, $urandom_range(1, 3), $urandom_range(1, 4));
        end
        echo  = 1'($urandom_range(0, 1));
        lim   = IDLE + n * (PRESS + GAP) + $urandom_range(0, 60);
        pr_at = ($urandom_range(0, 2) == 0) ? $urandom_range(IDLE, lim) : -1;
        for (int c = 0; c < lim; c++) begin
            leds   = echo ? botoes : 4'd0;
            pronto = (c == pr_at);
            tick();
        end
        leds   = 4'd0;
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("random_game_end_fim", int'(db_estado), 5);
        tick();
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        int n, ones;
        logic [11:0] seen;
        logic [3:0]  prevb;

        repeat (3) tick();
        chk("reset_botoes", int'(botoes), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        chk("reset_estado", int'(db_estado), 0);
        chk("reset_contagem", int'(db_contagem), 0);
        reset = 1'b1;
        tick();
        habilita = 1'b1;
        tick();

        // Basic round
        start();
        show(4'b0100, 3, 0);
        chk("basic_contagem", int'(db_contagem), 1);
        n = 0;
        while (botoes == 4'd0 && n < 300) begin
            tick();
            n++;
        end
        chk("basic_first_press_delay", n, IDLE + 1);
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            if (botoes == 4'b0100) ones++;
            tick();
        end
        chk("basic_press_cycles", ones, PRESS);
        chk("basic_back_to_observa", int'(db_estado), 2);

        // Three-step sequence
        show(4'b0001, 1, 4);
        show(4'b1000, 1, 4);
        show(4'b0010, 1, 4);
        n = 0;
        while (botoes == 4'd0 && n < 300) begin
            tick();
            n++;
        end
        seen  = 12'd0;
        prevb = 4'd0;
        n     = 0;
        while (db_estado != 4'd2 && n < 100) begin
            if (botoes != 4'd0 && botoes != prevb) seen = {seen[7:0], botoes};
            prevb = botoes;
            tick();
            n++;
        end
        chk("three_step_order", int'(seen), int'(12'b0001_1000_0010));
        chk("three_step_length", n, 3 * (PRESS + GAP));
        chk("three_step_cnt_cleared", int'(db_contagem), 0);

        // Error cases
        show(4'b0110, 1, 1);
        chk("non_onehot_erro", int'(db_erro), 1);
        chk("non_onehot_no_capture", int'(db_contagem), 0);
        for (int i = 0; i < 17; i++) begin
            show(4'b0001 << $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 3));
        end
        chk("overflow_contagem", int'(db_contagem), 16);
        chk("overflow_erro", int'(db_erro), 1);

        // Echo immunity during replay
        wait_state(4'd3, 300, "echo_reach_press");
        for (int i = 0; i < 30; i++) begin
            leds = botoes;
            tick();
        end
        leds = 4'd0;
        chk("echo_contagem", int'(db_contagem), 16);

        // pronto mid-press
        wait_state(4'd3, 50, "pronto_reach_press");
        tick();
        pronto = 1'b1;
        tick();
        pronto = 1'b0;
        chk("pronto_botoes", int'(botoes), 0);
        chk("pronto_estado", int'(db_estado), 5);
        chk("pronto_ocupado", int'(ocupado), 0);
        start();
        chk("restart_erro_cleared", int'(db_erro), 0);

        // habilita low in SOLTA
        show(4'b1000, 1, 2);
        wait_state(4'd4, 300, "disable_reach_solta");
        habilita = 1'b0;
        tick();
        chk("disable_estado", int'(db_estado), 0);
        habilita = 1'b1;
        tick();

        // Asynchronous reset mid-press
        start();
        show(4'b0100, 2, 2);
        wait_state(4'd3, 300, "reset_reach_press");
        tick();
        chk("press_before_reset", int'(botoes), int'(4'b0100));
        reset = 1'b0;
        #1;
        chk("async_reset_botoes", int'(botoes), 0);
        chk("async_reset_estado", int'(db_estado), 0);
        #1;
        reset = 1'b1;
        tick();

        for (int g = 0; g < 6; g++) random_game();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
